wb_arbiter: RTL and testbench

- Sequences the single register-file write port between the integer pipe (IP) and the load/store pipe (LSP) writeback interfaces.
- Acknowledges retire-without-writeback (RWOWB) requests unconditionally.
- Arbitrates contending writebacks round-robin or with fixed LSP priority, and registers the winning write for the issue stage's regfile and forwarding logic.
- Maintains the 64-bit retired-instruction counter.

---
 rtl/wb_arbiter_pkg.sv | 25 ++
 rtl/wb_arbiter_rr_arb2.sv | 62 ++++++
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_pkg
// Purpose : Shared constants and helpers for the writeback arbiter.
//           WB_ARB_RR / WB_ARB_LSP_PRIO select the ARB_MODE of wb_arbiter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package wb_arbiter_pkg;

   localparam int WB_ARB_RR       = 0;
   localparam int WB_ARB_LSP_PRIO = 1;
   localparam int REG_AW          = 5;

   // A side wants the write port only for a real register write; writes to
   // x0 are retired without touching the regfile. valid gates the other
   // terms so X on an idle side's en/dst evaluates to 0.
   function automatic logic wb_wreq(input logic              valid,
                                    input logic              en,
                                    input logic [REG_AW-1:0] dst);
      return valid && en && (dst != '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-input (IP / LSP) grant generator holding the round-robin
//           pointer. In LSP-priority mode the pointer still tracks the last
//           contention winner but does not steer the grant.
// Ports   : clk, rst          clock, async active-high reset
//           en                grants allowed (low while in reset)
//           req_ip, req_lsp   write-port requests
//           gnt_ip, gnt_lsp   one-hot (or zero) grants, combinational
//           last_grant_lsp    pointer: 1 = LSP won the last contention
// Rev     : 1.0  initial release
// ============================================================================
module rr_arb2
   import wb_arbiter_pkg::*;
#(
   parameter int ARB_MODE = WB_ARB_RR
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_ip,
   input  logic req_lsp,
   output logic gnt_ip,
   output logic gnt_lsp,
   output logic last_grant_lsp
);

   logic last_q;
   logic last_d;
   logic lsp_wins;
   logic contend;

   generate
      if (ARB_MODE == WB_ARB_LSP_PRIO) begin : g_lsp_prio
         assign lsp_wins = 1'b1;
      end else begin : g_round_robin
         assign lsp_wins = !last_q;
      end
   endgenerate

   always_comb begin
      contend = en && req_ip && req_lsp;
      gnt_lsp = en && req_lsp && (!req_ip || lsp_wins);
      gnt_ip  = en && req_ip && (!req_lsp || !lsp_wins);
      // Only a real contention moves the pointer.
      last_d  = contend ? gnt_lsp : last_q;
   end

   // Reset to 1 so IP wins the first contention in round-robin mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_grant_lsp = last_q;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Purpose : Shares the single regfile write port between the integer pipe
//           (IP) and load/store pipe (LSP) writebacks, acks retire-without-
//           writeback immediately, registers the winning write and counts
//           retired instructions.
// Ports   : clk, rst                       clock, async active-high reset
//           ip_wb_*  / lsp_wb_*            writeback valid/en/dst/result/pc
//           ip_wb_ready / lsp_wb_ready     handshake accepted this cycle
//           rf_we/rf_waddr/rf_wdata/rf_wpc registered write, 1 cycle later
//           instret                        retired-instruction count
//           last_grant_lsp                 round-robin pointer
// Rev     : 1.0  initial release
// ============================================================================
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int ARB_MODE = WB_ARB_RR,
   parameter int XLEN     = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ip_wb_valid,
   input  logic            ip_wb_en,
   input  logic [4:0]      ip_wb_dst,
   input  logic [XLEN-1:0] ip_wb_result,
   input  logic [XLEN-1:0] ip_wb_pc,
   output logic            ip_wb_ready,
   input  logic            lsp_wb_valid,
   input  logic            lsp_wb_en,
   input  logic [4:0]      lsp_wb_dst,
   input  logic [XLEN-1:0] lsp_wb_result,
   input  logic [XLEN-1:0] lsp_wb_pc,
   output logic            lsp_wb_ready,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [XLEN-1:0] rf_wpc,
   output logic [XLEN-1:0] instret,
   output logic            last_grant_lsp
);

   logic            arb_en;
   logic            wreq_ip;
   logic            wreq_lsp;
   logic            rwowb_ip;
   logic            rwowb_lsp;
   logic            gnt_ip;
   logic            gnt_lsp;
   logic            hs_ip;
   logic            hs_lsp;

   logic            rf_we_q,    rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic [XLEN-1:0] rf_wpc_q,   rf_wpc_d;
   logic [XLEN-1:0] instret_q,  instret_d;

   // Kept outside the main comb block so the request -> grant -> ready path
   // through the arbiter does not look like a combinational loop.
   assign arb_en   = !rst;
   assign wreq_ip  = wb_wreq(ip_wb_valid,  ip_wb_en,  ip_wb_dst);
   assign wreq_lsp = wb_wreq(lsp_wb_valid, lsp_wb_en, lsp_wb_dst);

   rr_arb2 #(
      .ARB_MODE       (ARB_MODE)
   ) u_arb (
      .clk            (clk),
      .rst            (rst),
      .en             (arb_en),
      .req_ip         (wreq_ip),
      .req_lsp        (wreq_lsp),
      .gnt_ip         (gnt_ip),
      .gnt_lsp        (gnt_lsp),
      .last_grant_lsp (last_grant_lsp)
   );

   always_comb begin
      rwowb_ip     = ip_wb_valid  && !wreq_ip;
      rwowb_lsp    = lsp_wb_valid && !wreq_lsp;
      ip_wb_ready  = arb_en && (!ip_wb_valid  || rwowb_ip  || gnt_ip);
      lsp_wb_ready = arb_en && (!lsp_wb_valid || rwowb_lsp || gnt_lsp);
      // Ready is high on an idle side, so a handshake also needs valid.
      hs_ip        = ip_wb_valid  && ip_wb_ready;
      hs_lsp       = lsp_wb_valid && lsp_wb_ready;

      rf_we_d      = gnt_ip || gnt_lsp;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      rf_wpc_d     = rf_wpc_q;
      if (gnt_lsp) begin
         rf_waddr_d = lsp_wb_dst;
         rf_wdata_d = lsp_wb_result;
         rf_wpc_d   = lsp_wb_pc;
      end else if (gnt_ip) begin
         rf_waddr_d = ip_wb_dst;
         rf_wdata_d = ip_wb_result;
         rf_wpc_d   = ip_wb_pc;
      end

      instret_d = instret_q + {{(XLEN-1){1'b0}}, hs_ip}
                            + {{(XLEN-1){1'b0}}, hs_lsp};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_wpc_q   <= '0;
         instret_q  <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_wpc_q   <= rf_wpc_d;
         instret_q  <= instret_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_wpc   = rf_wpc_q;
   assign instret  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Self-checking bench for wb_arbiter. Drives one stimulus stream
//           into a round-robin and an LSP-priority instance, plus a narrow
//           (XLEN=8) instance for the counter wrap.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

   localparam logic [63:0] IPC = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LPC = 64'h0000_0000_9000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        ip_v, ip_en, lsp_v, lsp_en;
   logic [4:0]  ip_dst, lsp_dst;
   logic [63:0] ip_res, ip_pc, lsp_res, lsp_pc;

   logic        ipr0, lspr0, we0, lg0;
   logic [4:0]  wa0;
   logic [63:0] wd0, wp0, ir0;
   logic        ipr1, lspr1, we1, lg1;
   logic [4:0]  wa1;
   logic [63:0] wd1, wp1, ir1;

   logic        w_v;
   logic        w_ipr, w_lspr, w_we, w_lg;
   logic [4:0]  w_wa;
   logic [7:0]  w_wd, w_wp, w_ir;

   wb_arbiter #(.ARB_MODE(0), .XLEN(64)) dut0 (
      .clk(clk), .rst(rst),
      .ip_wb_valid(ip_v), .ip_wb_en(ip_en), .ip_wb_dst(ip_dst),
      .ip_wb_result(ip_res), .ip_wb_pc(ip_pc), .ip_wb_ready(ipr0),
      .lsp_wb_valid(lsp_v), .lsp_wb_en(lsp_en), .lsp_wb_dst(lsp_dst),
      .lsp_wb_result(lsp_res), .lsp_wb_pc(lsp_pc), .lsp_wb_ready(lspr0),
      .rf_we(we0), .rf_waddr(wa0), .rf_wdata(wd0), .rf_wpc(wp0),
      .instret(ir0), .last_grant_lsp(lg0)
   );

   wb_arbiter #(.ARB_MODE(1), .XLEN(64)) dut1 (
      .clk(clk), .rst(rst),
      .ip_wb_valid(ip_v), .ip_wb_en(ip_en), .ip_wb_dst(ip_dst),
      .ip_wb_result(ip_res), .ip_wb_pc(ip_pc), .ip_wb_ready(ipr1),
      .lsp_wb_valid(lsp_v), .lsp_wb_en(lsp_en), .lsp_wb_dst(lsp_dst),
      .lsp_wb_result(lsp_res), .lsp_wb_pc(lsp_pc), .lsp_wb_ready(lspr1),
      .rf_we(we1), .rf_waddr(wa1), .rf_wdata(wd1), .rf_wpc(wp1),
      .instret(ir1), .last_grant_lsp(lg1)
   );

   wb_arbiter #(.ARB_MODE(0), .XLEN(8)) dutw (
      .clk(clk), .rst(rst),
      .ip_wb_valid(w_v), .ip_wb_en(1'b0), .ip_wb_dst(5'd0),
      .ip_wb_result(8'd0), .ip_wb_pc(8'd0), .ip_wb_ready(w_ipr),
      .lsp_wb_valid(1'b0), .lsp_wb_en(1'b0), .lsp_wb_dst(5'd0),
      .lsp_wb_result(8'd0), .lsp_wb_pc(8'd0), .lsp_wb_ready(w_lspr),
      .rf_we(w_we), .rf_waddr(w_wa), .rf_wdata(w_wd), .rf_wpc(w_wp),
      .instret(w_ir), .last_grant_lsp(w_lg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        iv, ie;
      logic [4:0]  idst;
      logic [63:0] ires;
      logic        lv, le;
      logic [4:0]  ldst;
      logic [63:0] lres;
      logic        ipr0, lspr0, ipr1, lspr1, we;
      logic [4:0]  a0;
      logic [63:0] d0;
      logic        s0;     // 1 = mode-0 registered write came from LSP
      logic [4:0]  a1;
      logic [63:0] d1;
      logic        s1;
      logic        last0, last1;
      int          inc;
   } vec_t;

   function automatic vec_t mk(input int iv, ie, idst, ires,
                               input int lv, le, ldst, lres,
                               input int ipr0, lspr0, ipr1, lspr1, we,
                               input int a0, d0, s0, a1, d1, s1,
                               input int last0, last1, inc);
      vec_t v;
      v.iv = iv[0];     v.ie = ie[0];   v.idst = idst[4:0]; v.ires = 64'(ires);
      v.lv = lv[0];     v.le = le[0];   v.ldst = ldst[4:0]; v.lres = 64'(lres);
      v.ipr0 = ipr0[0]; v.lspr0 = lspr0[0];
      v.ipr1 = ipr1[0]; v.lspr1 = lspr1[0]; v.we = we[0];
      v.a0 = a0[4:0];   v.d0 = 64'(d0); v.s0 = s0[0];
      v.a1 = a1[4:0];   v.d1 = 64'(d1); v.s1 = s1[0];
      v.last0 = last0[0]; v.last1 = last1[0]; v.inc = inc;
      return v;
   endfunction

   vec_t tbl[11];
   logic [63:0] exp_ir;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            ip: v e dst res    lsp: v e dst res  rdy m0  rdy m1 we  m0:a d s       m1:a d s   last0/1 inc
      tbl[0]  = mk(1,1,5,'h1234, 0,0,0,0,      1,1, 1,1, 1, 5,'h1234,0, 5,'h1234,0, 1,1, 1);
      tbl[1]  = mk(1,1,1,'h11,   1,1,2,'h22,   1,0, 0,1, 1, 1,'h11,0,   2,'h22,1,   0,1, 1);
      tbl[2]  = mk(1,1,1,'h11,   1,1,2,'h22,   0,1, 0,1, 1, 2,'h22,1,   2,'h22,1,   1,1, 1);
      tbl[3]  = mk(1,1,1,'h11,   1,1,2,'h22,   1,0, 0,1, 1, 1,'h11,0,   2,'h22,1,   0,1, 1);
      tbl[4]  = mk(1,1,1,'h11,   1,1,2,'h22,   0,1, 0,1, 1, 2,'h22,1,   2,'h22,1,   1,1, 1);
      tbl[5]  = mk(1,1,1,'h33,   0,0,0,0,      1,1, 1,1, 1, 1,'h33,0,   1,'h33,0,   1,1, 1);
      tbl[6]  = mk(1,0,0,0,      1,1,7,'h77,   1,1, 1,1, 1, 7,'h77,1,   7,'h77,1,   1,1, 2);
      tbl[7]  = mk(0,0,0,0,      1,1,0,'h99,   1,1, 1,1, 0, 7,'h77,1,   7,'h77,1,   1,1, 1);
      tbl[8]  = mk(0,0,0,0,      0,0,0,0,      1,1, 1,1, 0, 7,'h77,1,   7,'h77,1,   1,1, 0);
      tbl[9]  = mk(1,1,0,'h55,   1,0,9,'h66,   1,1, 1,1, 0, 7,'h77,1,   7,'h77,1,   1,1, 2);
      tbl[10] = mk(1,1,3,'h3,    1,1,4,'h4,    1,0, 0,1, 1, 3,'h3,0,    4,'h4,1,    0,1, 1);

      // Reset: inputs idle, everything cleared, readies low while rst high.
      rst = 1'b1; w_v = 1'b0;
      ip_v = 1'b0; ip_en = 1'b0; ip_dst = '0; ip_res = '0; ip_pc = '0;
      lsp_v = 1'b0; lsp_en = 1'b0; lsp_dst = '0; lsp_res = '0; lsp_pc = '0;
      exp_ir = '0;
      #1;
      chk("rst ip_ready",    64'(ipr0),  64'd0);
      chk("rst lsp_ready",   64'(lspr0), 64'd0);
      chk("rst rf_we",       64'(we0),   64'd0);
      chk("rst rf_waddr",    64'(wa0),   64'd0);
      chk("rst rf_wdata",    wd0,        64'd0);
      chk("rst rf_wpc",      wp0,        64'd0);
      chk("rst instret",     ir0,        64'd0);
      chk("rst last_grant0", 64'(lg0),   64'd1);
      chk("rst last_grant1", 64'(lg1),   64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         ip_v = tbl[i].iv;
         if (tbl[i].iv) begin
            ip_en = tbl[i].ie; ip_dst = tbl[i].idst;
            ip_res = tbl[i].ires; ip_pc = IPC;
         end else begin
            ip_en = 1'bx; ip_dst = 'x; ip_res = 'x; ip_pc = 'x;
         end
         lsp_v = tbl[i].lv;
         if (tbl[i].lv) begin
            lsp_en = tbl[i].le; lsp_dst = tbl[i].ldst;
            lsp_res = tbl[i].lres; lsp_pc = LPC;
         end else begin
            lsp_en = 1'bx; lsp_dst = 'x; lsp_res = 'x; lsp_pc = 'x;
         end
         #1;
         chk($sformatf("r%0d ip_ready m0", i),  64'(ipr0),  64'(tbl[i].ipr0));
         chk($sformatf("r%0d lsp_ready m0", i), 64'(lspr0), 64'(tbl[i].lspr0));
         chk($sformatf("r%0d ip_ready m1", i),  64'(ipr1),  64'(tbl[i].ipr1));
         chk($sformatf("r%0d lsp_ready m1", i), 64'(lspr1), 64'(tbl[i].lspr1));
         @(posedge clk);
         #1;
         exp_ir = exp_ir + 64'(tbl[i].inc);
         chk($sformatf("r%0d rf_we m0", i),    64'(we0), 64'(tbl[i].we));
         chk($sformatf("r%0d rf_waddr m0", i), 64'(wa0), 64'(tbl[i].a0));
         chk($sformatf("r%0d rf_wdata m0", i), wd0,      tbl[i].d0);
         chk($sformatf("r%0d rf_wpc m0", i),   wp0,      tbl[i].s0 ? LPC : IPC);
         chk($sformatf("r%0d last m0", i),     64'(lg0), 64'(tbl[i].last0));
         chk($sformatf("r%0d instret m0", i),  ir0,      exp_ir);
         chk($sformatf("r%0d rf_we m1", i),    64'(we1), 64'(tbl[i].we));
         chk($sformatf("r%0d rf_waddr m1", i), 64'(wa1), 64'(tbl[i].a1));
         chk($sformatf("r%0d rf_wdata m1", i), wd1,      tbl[i].d1);
         chk($sformatf("r%0d rf_wpc m1", i),   wp1,      tbl[i].s1 ? LPC : IPC);
         chk($sformatf("r%0d last m1", i),     64'(lg1), 64'(tbl[i].last1));
         chk($sformatf("r%0d instret m1", i),  ir1,      exp_ir);
      end

      // Contention again (mode-0 pointer is 0, so LSP wins), then an
      // asynchronous reset between clock edges.
      @(negedge clk);
      ip_v = 1'b1;  ip_en = 1'b1;  ip_dst = 5'd3;  ip_res = 64'h3;  ip_pc = IPC;
      lsp_v = 1'b1; lsp_en = 1'b1; lsp_dst = 5'd4; lsp_res = 64'h4; lsp_pc = LPC;
      @(posedge clk);
      #1;
      chk("pre-rst rf_waddr m0", 64'(wa0), 64'd4);
      chk("pre-rst last m0",     64'(lg0), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst ip_ready m0",  64'(ipr0),  64'd0);
      chk("arst lsp_ready m0", 64'(lspr0), 64'd0);
      chk("arst ip_ready m1",  64'(ipr1),  64'd0);
      chk("arst lsp_ready m1", 64'(lspr1), 64'd0);
      chk("arst rf_we m0",     64'(we0),   64'd0);
      chk("arst rf_waddr m0",  64'(wa0),   64'd0);
      chk("arst rf_wdata m0",  wd0,        64'd0);
      chk("arst rf_wpc m0",    wp0,        64'd0);
      chk("arst instret m0",   ir0,        64'd0);
      chk("arst instret m1",   ir1,        64'd0);
      chk("arst last m0",      64'(lg0),   64'd1);
      chk("arst last m1",      64'(lg1),   64'd1);
      @(negedge clk);
      ip_v = 1'b0; lsp_v = 1'b0;
      rst = 1'b0;

      // Counter wrap on the 8-bit instance: 255 retires then one more.
      @(negedge clk);
      w_v = 1'b1;
      #1;
      chk("wrap ip_ready", 64'(w_ipr), 64'd1);
      repeat (255) @(posedge clk);
      #1;
      chk("wrap instret max", 64'(w_ir), 64'hFF);
      @(posedge clk);
      #1;
      chk("wrap instret zero", 64'(w_ir), 64'd0);
      chk("idle instret m0",   ir0,       64'd0);
      chk("idle rf_we m0",     64'(we0),  64'd0);
      @(negedge clk);
      w_v = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
